// File: rtl/counter_checker.sv
// Checks a monitored up-counter against a cycle-accurate prediction and tracks mismatches.
// Optional macro COUNTER_CHECKER_WRAP_CNT_EN adds a saturating wrap counter output.
module counter_checker #(
    parameter int WIDTH         = 8,
    parameter int ERR_CNT_WIDTH = 16,
    parameter int ERR_LIMIT     = 4
) (
    input  logic                     i_clock,
    input  logic                     i_clear_n,
    input  logic                     i_dut_clear,
    input  logic                     i_count,
    input  logic [WIDTH-1:0]         i_q,
    output logic [WIDTH-1:0]         o_expected,
    output logic                     o_locked,
    output logic                     o_error,
    output logic                     o_fault,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count,
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    output logic [15:0]              o_wrap_count,
`endif
    output logic [1:0]               o_state
);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [ERR_CNT_WIDTH-1:0] LIMIT = ERR_CNT_WIDTH'(ERR_LIMIT);

    logic [1:0]               r_state;
    logic [WIDTH-1:0]         r_expected;
    logic                     r_error;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    logic [WIDTH-1:0]         w_pred;
    logic                     w_mismatch;
    logic [ERR_CNT_WIDTH-1:0] w_err_next;

    // The prediction is always rebuilt from the observed q, so a mismatch resyncs for free.
    assign w_pred     = i_dut_clear ? '0 : (i_count ? i_q + WIDTH'(1) : i_q);
    assign w_mismatch = (r_state != ST_SYNC) && (i_q != r_expected);
    assign w_err_next = (&r_err_count) ? r_err_count : r_err_count + ERR_CNT_WIDTH'(1);

    always_ff @(posedge i_clock) begin
        if (!i_clear_n) begin
            r_state     <= ST_SYNC;
            r_expected  <= '0;
            r_error     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_expected <= w_pred;
            r_error    <= w_mismatch;
            if (w_mismatch) begin
                r_err_count <= w_err_next;
            end
            case (r_state)
                ST_SYNC:  r_state <= ST_TRACK;
                ST_TRACK: begin
                    if (w_mismatch && (w_err_next >= LIMIT)) begin
                        r_state <= ST_FAULT;
                    end
                end
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_SYNC;
            endcase
        end
    end

`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    logic        r_wrap_pend;
    logic [15:0] r_wrap_count;

    // A wrap counts only when the edge after a max->0 prediction confirms it.
    always_ff @(posedge i_clock) begin
        if (!i_clear_n) begin
            r_wrap_pend  <= 1'b0;
            r_wrap_count <= '0;
        end else begin
            r_wrap_pend <= (&i_q) && i_count && !i_dut_clear;
            if (r_wrap_pend && (r_state != ST_SYNC) && !w_mismatch && !(&r_wrap_count)) begin
                r_wrap_count <= r_wrap_count + 16'd1;
            end
        end
    end

    assign o_wrap_count = r_wrap_count;
`endif

    assign o_expected  = r_expected;
    assign o_locked    = (r_state == ST_TRACK);
    assign o_error     = r_error;
    assign o_fault     = (r_state == ST_FAULT);
    assign o_err_count = r_err_count;
    assign o_state     = r_state;

endmodule

// File: tb/tb_counter_checker.sv
// Directed vector-table bench for counter_checker (WIDTH=8, ERR_LIMIT=4).
// Honours COUNTER_CHECKER_WRAP_CNT_EN when the design is built with it.
module tb_counter_checker;

    logic        clk;
    logic        clear_n;
    logic        dut_clear;
    logic        count;
    logic [7:0]  q;
    logic [7:0]  expected;
    logic        locked;
    logic        error;
    logic        fault;
    logic [15:0] err_count;
    logic [1:0]  state;
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    logic [15:0] wrap_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    counter_checker #(.WIDTH(8), .ERR_CNT_WIDTH(16), .ERR_LIMIT(4)) dut (
        .i_clock      (clk),
        .i_clear_n    (clear_n),
        .i_dut_clear  (dut_clear),
        .i_count      (count),
        .i_q          (q),
        .o_expected   (expected),
        .o_locked     (locked),
        .o_error      (error),
        .o_fault      (fault),
        .o_err_count  (err_count),
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
        .o_wrap_count (wrap_count),
`endif
        .o_state      (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        dc;
        logic        cnt;
        logic [7:0]  q;
        logic [7:0]  e_exp;
        logic        e_lock;
        logic        e_err;
        logic        e_fault;
        logic [15:0] e_n;
    } vec_t;

    vec_t vecs[19];

    // Apply one set of inputs across one rising edge; outputs are sampled 1 ns later.
    task automatic step(input logic rn, input logic dc, input logic cnt, input logic [7:0] qv);
        clear_n   = rn;
        dut_clear = dc;
        count     = cnt;
        q         = qv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] ee, input logic el,
                       input logic eerr, input logic ef, input logic [15:0] en);
        n_checks++;
        if (expected !== ee) begin
            n_errors++;
            $display("FAIL %s expected: got %h want %h", nm, expected, ee);
        end
        n_checks++;
        if (locked !== el) begin
            n_errors++;
            $display("FAIL %s locked: got %b want %b", nm, locked, el);
        end
        n_checks++;
        if (error !== eerr) begin
            n_errors++;
            $display("FAIL %s error: got %b want %b", nm, error, eerr);
        end
        n_checks++;
        if (fault !== ef) begin
            n_errors++;
            $display("FAIL %s fault: got %b want %b", nm, fault, ef);
        end
        n_checks++;
        if (err_count !== en) begin
            n_errors++;
            $display("FAIL %s err_count: got %0d want %0d", nm, err_count, en);
        end
    endtask

    task automatic chk_state(input string nm, input logic [1:0] es);
        n_checks++;
        if (state !== es) begin
            n_errors++;
            $display("FAIL %s state: got %0d want %0d", nm, state, es);
        end
    endtask

`ifdef COUNTER_CHECKER_WRAP_CNT_EN
    task automatic chk_wrap(input string nm, input logic [15:0] ew);
        n_checks++;
        if (wrap_count !== ew) begin
            n_errors++;
            $display("FAIL %s wrap_count: got %0d want %0d", nm, wrap_count, ew);
        end
    endtask
`endif

    initial begin
        logic [7:0] qm;

        clear_n   = 1'b0;
        dut_clear = 1'b0;
        count     = 1'b0;
        q         = 8'h00;

        //            rn    dc    cnt   q      exp    lock  err   flt   n
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h05, 8'h06, 1'b1, 1'b1, 1'b0, 16'd1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h06, 8'h07, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h09, 8'h0A, 1'b1, 1'b1, 1'b0, 16'd2};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h0B, 8'h0C, 1'b1, 1'b1, 1'b0, 16'd3};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h0C, 8'h0D, 1'b1, 1'b0, 1'b0, 16'd3};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h20, 8'h21, 1'b0, 1'b1, 1'b1, 16'd4};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h21, 8'h22, 1'b0, 1'b0, 1'b1, 16'd4};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h30, 8'h31, 1'b0, 1'b1, 1'b1, 16'd5};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h11, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 8'h11, 8'h12, 1'b1, 1'b0, 1'b0, 16'd0};

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rn, vecs[i].dc, vecs[i].cnt, vecs[i].q);
            chk($sformatf("vec%0d", i), vecs[i].e_exp, vecs[i].e_lock,
                vecs[i].e_err, vecs[i].e_fault, vecs[i].e_n);
        end

        // Long correct count through one 8-bit wrap.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h3C);
        chk("run_sync", 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        qm = 8'h00;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b1, qm);
            qm = qm + 8'd1;
            chk($sformatf("run%0d", i), qm, 1'b1, 1'b0, 1'b0, 16'd0);
        end
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
        chk_wrap("run_wrap", 16'd1);
`endif

        // Single wrong value then the counter continues from it.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h0E);
        chk("skip_sync", 8'h0F, 1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 1'b1, 8'h10);
        chk("skip_bad", 8'h11, 1'b1, 1'b1, 1'b0, 16'd1);
        step(1'b1, 1'b0, 1'b1, 8'h11);
        chk("skip_ok", 8'h12, 1'b1, 1'b0, 1'b0, 16'd1);

        // Hold at max, then wrap.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        chk("hold_sync", 8'hFF, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'hFF);
            chk($sformatf("hold%0d", i), 8'hFF, 1'b1, 1'b0, 1'b0, 16'd0);
        end
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        chk("hold_go", 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("hold_wrap", 8'h01, 1'b1, 1'b0, 1'b0, 16'd0);
`ifdef COUNTER_CHECKER_WRAP_CNT_EN
        chk_wrap("hold_wrapcnt", 16'd1);
`endif

        // Three errors, then a one-cycle reset mid-count.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk_state("mid_sync", 2'd1);
        step(1'b1, 1'b0, 1'b1, 8'h40);
        chk("mid_e1", 8'h41, 1'b1, 1'b1, 1'b0, 16'd1);
        step(1'b1, 1'b0, 1'b1, 8'h41);
        step(1'b1, 1'b0, 1'b1, 8'h50);
        chk("mid_e2", 8'h51, 1'b1, 1'b1, 1'b0, 16'd2);
        step(1'b1, 1'b0, 1'b1, 8'h51);
        step(1'b1, 1'b0, 1'b1, 8'h60);
        chk("mid_e3", 8'h61, 1'b1, 1'b1, 1'b0, 16'd3);
        step(1'b0, 1'b1, 1'b1, 8'h61);
        chk("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
        chk_state("mid_rst", 2'd0);
        step(1'b1, 1'b0, 1'b1, 8'h99);
        chk("mid_resync", 8'h9A, 1'b1, 1'b0, 1'b0, 16'd0);
        chk_state("mid_resync", 2'd1);
        step(1'b1, 1'b0, 1'b1, 8'h9A);
        chk("mid_track", 8'h9B, 1'b1, 1'b0, 1'b0, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter WIDTH, default 8, sets the width of the monitored counter value.
REQ-002 Parameter ERR_CNT_WIDTH, default 16, sets the width of the mismatch counter.
REQ-003 Parameter ERR_LIMIT, default 4, sets the mismatch count at which the block enters FAULT (1..2^ERR_CNT_WIDTH-1).
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 clear_n  input  1  synchronous active-low reset.
REQ-006 dut_clear  input  1  active-high clear applied to the monitored counter.
REQ-007 count  input  1  count enable applied to the monitored counter.
REQ-008 q  input  WIDTH  monitored counter output.
REQ-009 expected  output  WIDTH  predicted value of q for the current edge.
REQ-010 locked  output  1  high while in TRACK.
REQ-011 error  output  1  one-cycle mismatch pulse.
REQ-012 fault  output  1  high while in FAULT.
REQ-013 err_count  output  ERR_CNT_WIDTH  number of mismatches since reset.

Function
REQ-014 The block SHALL sample dut_clear, count and q at each rising clock edge.
REQ-015 Prediction rule: if dut_clear was high at the previous edge, the next q is 0; else if count was high, it is prev q + 1 mod 2^WIDTH; else it is prev q.
REQ-016 dut_clear SHALL take priority over count when both are high.
REQ-017 Wrap-around: q=2^WIDTH-1 with count=1 SHALL predict 0, and a q of 0 at that point is not a mismatch.
REQ-018 The FSM SHALL have three states, SYNC, TRACK and FAULT; reset state is SYNC.
REQ-019 SYNC: no comparison; at the first edge, load the prediction from the sampled values and move to TRACK.
REQ-020 TRACK: compare sampled q with expected at every edge.
REQ-021 On a TRACK mismatch: pulse error for one cycle, increment err_count, and reload the prediction from the observed q (resync).
REQ-022 error SHALL be registered and high in the cycle after the edge that sampled the mismatching q.
REQ-023 err_count SHALL saturate at 2^ERR_CNT_WIDTH-1 and never wrap.
REQ-024 TRACK->FAULT SHALL occur on the edge where err_count reaches ERR_LIMIT.
REQ-025 FAULT SHALL be sticky until clear_n; in FAULT, comparison and error pulses continue and err_count keeps incrementing.
REQ-026 Back-to-back mismatches SHALL each produce an error pulse, so error may stay high for consecutive cycles.

Reset
REQ-027 With clear_n low at an edge, state SHALL go to SYNC, expected=0, locked=0, error=0, fault=0, err_count=0.
REQ-028 Reset mid-operation SHALL discard the prediction; one SYNC cycle SHALL follow before any comparison.
REQ-029 Inputs SHALL be ignored while clear_n is low.

Configuration
REQ-030 Macro COUNTER_CHECKER_WRAP_CNT_EN controls a wrap-count feature.
REQ-031 When it is defined, output port wrap_count[15:0] SHALL exist, reset to 0, and increment (saturating) on each correctly predicted wrap from 2^WIDTH-1 to 0 in TRACK or FAULT.
REQ-032 When it is undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, dut_clear pulse, count=1 for 300 cycles with a correct counter -> locked=1 after 1 cycle, error never asserted, err_count=0, wrap_count=1 (if enabled).
REQ-034 Force q=8'h10 when 8'h0F is expected -> one error pulse, err_count=1, subsequent 8'h11 accepted with no error.
REQ-035 Four isolated mismatches with ERR_LIMIT=4 -> fault=1 and locked=0 after the 4th; a further mismatch -> err_count=5, fault stays 1.
REQ-036 dut_clear=1 and count=1 together with q=8'h42 -> expected=0 next edge; q=0 gives no error, q=8'h43 gives an error.
REQ-037 count=0 hold for 10 cycles at q=8'hFF, then count=1 -> no error while q is held, and q=0 accepted after the wrap.
REQ-038 clear_n low for 1 cycle mid-count with err_count=3 -> all outputs at reset values, SYNC for one cycle, then TRACK with no spurious error.
